dec10b_crc_rx: RTL and testbench

//  Receive-side stage directly downstream of the packet encoder (K-flagged byte -> CRC32 -> 8b/10b).

---
 rtl/dec10b_crc_rx.sv | 191 +++++++++++++++++++
 tb/tb_dec10b_crc_rx.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec10b_crc_rx.sv
// 8b/10b receive stage: decodes symbols, tracks running disparity, follows K28.1/K28.5
// framing and checks the CRC32 residue over payload+FCS. Fixed two-cycle latency.
module dec10b_crc_rx #(
   parameter int LENW    = 16,
   parameter int ERRCNTW = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pushin,
   input  logic               startin,
   input  logic [9:0]         datain,
   output logic               pushout,
   output logic               startout,
   output logic [8:0]         dataout,
   output logic               code_err,
   output logic               disp_err,
   output logic               frame_end,
   output logic               crc_ok,
   output logic [LENW-1:0]    frame_len,
   output logic [ERRCNTW-1:0] code_cnt,
   output logic [ERRCNTW-1:0] disp_cnt
);

   typedef enum logic {IDLE, IN_FRAME} state_t;

   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
   localparam logic [8:0]  K28_1       = 9'h13C;
   localparam logic [8:0]  K28_5       = 9'h1BC;

   // Returns {valid, EDCBA}; both disparity forms of each 6b code map to the same value.
   function automatic logic [5:0] dec6(input logic [5:0] s);
      case (s)
         6'b100111, 6'b011000: dec6 = {1'b1, 5'd0};
         6'b011101, 6'b100010: dec6 = {1'b1, 5'd1};
         6'b101101, 6'b010010: dec6 = {1'b1, 5'd2};
         6'b110001:            dec6 = {1'b1, 5'd3};
         6'b110101, 6'b001010: dec6 = {1'b1, 5'd4};
         6'b101001:            dec6 = {1'b1, 5'd5};
         6'b011001:            dec6 = {1'b1, 5'd6};
         6'b111000, 6'b000111: dec6 = {1'b1, 5'd7};
         6'b111001, 6'b000110: dec6 = {1'b1, 5'd8};
         6'b100101:            dec6 = {1'b1, 5'd9};
         6'b010101:            dec6 = {1'b1, 5'd10};
         6'b110100:            dec6 = {1'b1, 5'd11};
         6'b001101:            dec6 = {1'b1, 5'd12};
         6'b101100:            dec6 = {1'b1, 5'd13};
         6'b011100:            dec6 = {1'b1, 5'd14};
         6'b010111, 6'b101000: dec6 = {1'b1, 5'd15};
         6'b011011, 6'b100100: dec6 = {1'b1, 5'd16};
         6'b100011:            dec6 = {1'b1, 5'd17};
         6'b010011:            dec6 = {1'b1, 5'd18};
         6'b110010:            dec6 = {1'b1, 5'd19};
         6'b001011:            dec6 = {1'b1, 5'd20};
         6'b101010:            dec6 = {1'b1, 5'd21};
         6'b011010:            dec6 = {1'b1, 5'd22};
         6'b111010, 6'b000101: dec6 = {1'b1, 5'd23};
         6'b110011, 6'b001100: dec6 = {1'b1, 5'd24};
         6'b100110:            dec6 = {1'b1, 5'd25};
         6'b010110:            dec6 = {1'b1, 5'd26};
         6'b110110, 6'b001001: dec6 = {1'b1, 5'd27};
         6'b001110:            dec6 = {1'b1, 5'd28};
         6'b101110, 6'b010001: dec6 = {1'b1, 5'd29};
         6'b011110, 6'b100001: dec6 = {1'b1, 5'd30};
         6'b101011, 6'b010100: dec6 = {1'b1, 5'd31};
         6'b001111, 6'b110000: dec6 = {1'b1, 5'd28};
         default:              dec6 = 6'd0;
      endcase
   endfunction

   // Returns {valid, HGF}; P7 and A7 both decode to 7.
   function automatic logic [3:0] dec4(input logic [3:0] s);
      case (s)
         4'b1011, 4'b0100:                   dec4 = {1'b1, 3'd0};
         4'b1001:                            dec4 = {1'b1, 3'd1};
         4'b0101:                            dec4 = {1'b1, 3'd2};
         4'b1100, 4'b0011:                   dec4 = {1'b1, 3'd3};
         4'b1101, 4'b0010:                   dec4 = {1'b1, 3'd4};
         4'b1010:                            dec4 = {1'b1, 3'd5};
         4'b0110:                            dec4 = {1'b1, 3'd6};
         4'b1110, 4'b0001, 4'b0111, 4'b1000: dec4 = {1'b1, 3'd7};
         default:                            dec4 = 4'd0;
      endcase
   endfunction

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'd0, b};
      for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction

   logic           push_q, start_q;
   logic [9:0]     sym_q;
   logic           rd;
   state_t         state;
   logic [31:0]    crc;
   logic [LENW-1:0] len;

   logic [5:0] s6;
   logic [3:0] s4, s4_eff;
   logic [4:0] dx;
   logic [2:0] dy;
   logic       v6, v4, k, cerr, derr, bad6, bad4, rd6, rd4;
   logic [8:0] dout;
   int         ones6, ones4;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      s6     = {sym_q[0], sym_q[1], sym_q[2], sym_q[3], sym_q[4], sym_q[5]};
      s4     = {sym_q[6], sym_q[7], sym_q[8], sym_q[9]};
      // K28 in its RD+ form is the bitwise complement of the RD- form, 4b part included.
      s4_eff = (s6 == 6'b110000) ? ~s4 : s4;
      {v6, dx} = dec6(s6);
      {v4, dy} = dec4(s4_eff);
      k = (s6 == 6'b001111) || (s6 == 6'b110000) ||
          (((s4 == 4'b0111) || (s4 == 4'b1000)) &&
           ((dx == 5'd23) || (dx == 5'd27) || (dx == 5'd29) || (dx == 5'd30)));
      cerr  = !(v6 && v4);
      dout  = cerr ? 9'h000 : {k, dy, dx};
      ones6 = $countones(s6);
      ones4 = $countones(s4);
      bad6  = ((ones6 > 3) && rd) || ((ones6 < 3) && !rd) ||
              ((s6 == 6'b000111) && !rd) || ((s6 == 6'b111000) && rd);
      rd6   = ((ones6 > 3) || (s6 == 6'b000111)) ? 1'b1 :
              ((ones6 < 3) || (s6 == 6'b111000)) ? 1'b0 : rd;
      bad4  = ((ones4 > 2) && rd6) || ((ones4 < 2) && !rd6) ||
              ((s4 == 4'b0011) && !rd6) || ((s4 == 4'b1100) && rd6);
      rd4   = ((ones4 > 2) || (s4 == 4'b0011)) ? 1'b1 :
              ((ones4 < 2) || (s4 == 4'b1100)) ? 1'b0 : rd6;
      derr  = !cerr && (bad6 || bad4);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         push_q    <= 1'b0;
         start_q   <= 1'b0;
         sym_q     <= '0;
         rd        <= 1'b0;
         state     <= IDLE;
         crc       <= CRC_INIT;
         len       <= '0;
         pushout   <= 1'b0;
         startout  <= 1'b0;
         dataout   <= '0;
         code_err  <= 1'b0;
         disp_err  <= 1'b0;
         frame_end <= 1'b0;
         crc_ok    <= 1'b0;
         frame_len <= '0;
         code_cnt  <= '0;
         disp_cnt  <= '0;
      end else begin
         push_q    <= pushin;
         start_q   <= startin;
         sym_q     <= datain;
         pushout   <= push_q;
         startout  <= push_q && start_q;
         dataout   <= push_q ? dout : 9'h000;
         code_err  <= push_q && cerr;
         disp_err  <= push_q && derr;
         frame_end <= 1'b0;
         crc_ok    <= 1'b0;
         if (push_q) begin
            rd <= rd4;
            if (cerr && (code_cnt != '1)) code_cnt <= code_cnt + 1'b1;
            if (derr && (disp_cnt != '1)) disp_cnt <= disp_cnt + 1'b1;
            if (start_q && !cerr && (dout == K28_1)) begin
               state <= IN_FRAME;
               crc   <= CRC_INIT;
               len   <= '0;
            end else if (state == IN_FRAME) begin
               if (cerr) begin
                  state <= IDLE;
               end else if (!k) begin
                  crc <= crc_byte(crc, dout[7:0]);
                  if (len != '1) len <= len + 1'b1;
               end else if (dout == K28_5) begin
                  frame_end <= 1'b1;
                  crc_ok    <= (crc == CRC_RESIDUE) && (len >= LENW'(4));
                  frame_len <= len;
                  state     <= IDLE;
               end else begin
                  state <= IDLE;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_dec10b_crc_rx.sv
// Bench for dec10b_crc_rx: a table of single-symbol decode vectors streamed back to back,
// then hand-built frames covering good/bad CRC, short frame, restart, abort and reset.
module tb_dec10b_crc_rx;

   logic        clk = 1'b0;
   logic        reset;
   logic        pushin, startin;
   logic [9:0]  datain;
   logic        pushout, startout, code_err, disp_err, frame_end, crc_ok;
   logic [8:0]  dataout;
   logic [15:0] frame_len;
   logic [7:0]  code_cnt, disp_cnt;

   dec10b_crc_rx dut (
      .clk(clk), .reset(reset), .pushin(pushin), .startin(startin), .datain(datain),
      .pushout(pushout), .startout(startout), .dataout(dataout), .code_err(code_err),
      .disp_err(disp_err), .frame_end(frame_end), .crc_ok(crc_ok), .frame_len(frame_len),
      .code_cnt(code_cnt), .disp_cnt(disp_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Symbol written as abcdei / fghj (a leftmost) placed into datain bit order.
   function automatic logic [9:0] pack(input logic [5:0] s6, input logic [3:0] s4);
      logic [9:0] r;
      for (int i = 0; i < 6; i++) r[i] = s6[5-i];
      for (int j = 0; j < 4; j++) r[6+j] = s4[3-j];
      return r;
   endfunction

   function automatic logic [31:0] crc_bits(input logic [31:0] c, input logic [7:0] b);
      logic fb;
      for (int i = 0; i < 8; i++) begin
         fb = c[0] ^ b[i];
         c  = c >> 1;
         if (fb) c = c ^ 32'hEDB8_8320;
      end
      return c;
   endfunction

   // Encoder tables, RD- column only; the RD+ column is derived.
   logic [5:0] t6 [32];
   logic [3:0] t4 [8];
   bit         tb_rd;

   task automatic enc_byte(input logic [7:0] b, output logic [9:0] sym);
      logic [5:0] six;
      logic [3:0] four;
      logic [4:0] x;
      logic [2:0] y;
      bit         a7;
      x = b[4:0];
      y = b[7:5];
      six = t6[x];
      if (tb_rd && (($countones(six) != 3) || (six == 6'b111000))) six = ~six;
      if ($countones(six) != 3) tb_rd = ~tb_rd;
      a7 = (y == 3'd7) && ((!tb_rd && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                           (tb_rd && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
      four = a7 ? 4'b0111 : t4[y];
      if (tb_rd && (($countones(four) != 2) || (four == 4'b1100))) four = ~four;
      if ($countones(four) != 2) tb_rd = ~tb_rd;
      sym = pack(six, four);
   endtask

   logic [11:0] stream [$];
   int          fe_cnt;
   logic        fe_ok;
   logic [15:0] fe_len;
   bit          ce_seen;
   logic [7:0]  payload [8];

   task automatic add_sym(input bit start, input logic [9:0] s);
      stream.push_back({1'b1, start, s});
   endtask

   task automatic add_k(input bit is_end, input bit start);
      logic [9:0] s;
      if (tb_rd) s = is_end ? pack(6'b110000, 4'b0101) : pack(6'b110000, 4'b0110);
      else       s = is_end ? pack(6'b001111, 4'b1010) : pack(6'b001111, 4'b1001);
      tb_rd = ~tb_rd;
      add_sym(start, s);
   endtask

   task automatic add_byte(input logic [7:0] b);
      logic [9:0] s;
      enc_byte(b, s);
      add_sym(1'b0, s);
   endtask

   task automatic add_frame(input bit flip);
      logic [31:0] c;
      logic [7:0]  b;
      c = 32'hFFFF_FFFF;
      add_k(1'b0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         c = crc_bits(c, payload[i]);
         b = payload[i];
         if (flip && i == 2) b = b ^ 8'h01;
         add_byte(b);
      end
      c = ~c;
      for (int i = 0; i < 4; i++) add_byte(c[8*i +: 8]);
      add_k(1'b1, 1'b0);
   endtask

   task automatic sample();
      if (frame_end) begin
         fe_cnt++;
         fe_ok  = crc_ok;
         fe_len = frame_len;
      end
      if (code_err) ce_seen = 1'b1;
   endtask

   task automatic run_stream(input int ntail);
      fe_cnt  = 0;
      fe_ok   = 1'b0;
      fe_len  = '0;
      ce_seen = 1'b0;
      foreach (stream[i]) begin
         @(negedge clk);
         sample();
         {pushin, startin, datain} = stream[i];
      end
      repeat (ntail) begin
         @(negedge clk);
         sample();
         pushin  = 1'b0;
         startin = 1'b0;
      end
      stream.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      pushin  = 1'b0;
      startin = 1'b0;
      reset   = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      tb_rd = 1'b0;
   endtask

   function automatic logic [63:0] all_outs();
      return {pushout, startout, dataout, code_err, disp_err, frame_end, crc_ok,
              frame_len, code_cnt, disp_cnt};
   endfunction

   typedef struct {
      logic       push;
      logic [9:0] sym;
      logic [8:0] data;
      logic       cerr;
      logic       derr;
      logic [7:0] ccnt;
      logic [7:0] dcnt;
   } vec_t;

   localparam int NV = 11;
   vec_t vecs [NV];

   initial begin
      t6 = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001,
             6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100,
             6'b011100, 6'b010111, 6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011,
             6'b101010, 6'b011010, 6'b111010, 6'b110011, 6'b100110, 6'b010110, 6'b110110,
             6'b001110, 6'b101110, 6'b011110, 6'b101011};
      t4 = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
      payload = '{8'h0A, 8'h0C, 8'h0E, 8'h10, 8'h12, 8'h14, 8'h16, 8'h18};

      // Running disparity carries from row to row, starting negative after reset.
      vecs[0]  = '{1'b1, pack(6'b100111, 4'b0100), 9'h000, 1'b0, 1'b0, 8'd0, 8'd0}; // D0.0 RD-
      vecs[1]  = '{1'b1, pack(6'b101010, 4'b1010), 9'h0B5, 1'b0, 1'b0, 8'd0, 8'd0}; // D21.5
      vecs[2]  = '{1'b1, pack(6'b110000, 4'b0101), 9'h1BC, 1'b0, 1'b1, 8'd0, 8'd1}; // K28.5 RD+ at RD-
      vecs[3]  = '{1'b1, pack(6'b111111, 4'b0000), 9'h000, 1'b1, 1'b0, 8'd1, 8'd1}; // invalid
      vecs[4]  = '{1'b1, pack(6'b001111, 4'b1001), 9'h13C, 1'b0, 1'b0, 8'd1, 8'd1}; // K28.1 RD-
      vecs[5]  = '{1'b0, pack(6'b111111, 4'b0000), 9'h000, 1'b0, 1'b0, 8'd1, 8'd1}; // no push
      vecs[6]  = '{1'b1, pack(6'b000111, 4'b0001), 9'h0E7, 1'b0, 1'b0, 8'd1, 8'd1}; // D7.7 RD+
      vecs[7]  = '{1'b1, pack(6'b100011, 4'b0111), 9'h0F1, 1'b0, 1'b0, 8'd1, 8'd1}; // D17.7 A7 RD-
      vecs[8]  = '{1'b1, pack(6'b000101, 4'b0111), 9'h1F7, 1'b0, 1'b0, 8'd1, 8'd1}; // K23.7 RD+
      vecs[9]  = '{1'b1, pack(6'b011000, 4'b1011), 9'h000, 1'b0, 1'b0, 8'd1, 8'd1}; // D0.0 RD+
      vecs[10] = '{1'b1, pack(6'b100111, 4'b0100), 9'h000, 1'b0, 1'b1, 8'd1, 8'd2}; // D0.0 RD- at RD+

      pushin  = 1'b0;
      startin = 1'b0;
      datain  = '0;
      reset   = 1'b1;
      tb_rd   = 1'b0;
      #1;
      check("reset_outputs", all_outs(), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("post_reset_outputs", all_outs(), 64'd0);

      for (int i = 0; i < NV + 2; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            if (vecs[i-2].push) begin
               check($sformatf("vec%0d_pushout", i-2), pushout, 1'b1);
               check($sformatf("vec%0d_data", i-2), dataout, vecs[i-2].data);
               check($sformatf("vec%0d_code_err", i-2), code_err, vecs[i-2].cerr);
               check($sformatf("vec%0d_disp_err", i-2), disp_err, vecs[i-2].derr);
               check($sformatf("vec%0d_code_cnt", i-2), code_cnt, vecs[i-2].ccnt);
               check($sformatf("vec%0d_disp_cnt", i-2), disp_cnt, vecs[i-2].dcnt);
               check($sformatf("vec%0d_frame_end", i-2), frame_end, 1'b0);
            end else begin
               check($sformatf("vec%0d_pushout", i-2), pushout, 1'b0);
            end
         end
         if (i < NV) begin
            pushin  = vecs[i].push;
            startin = 1'b0;
            datain  = vecs[i].sym;
         end else begin
            pushin = 1'b0;
         end
      end

      do_reset();
      add_frame(1'b0);
      run_stream(4);
      check("good_frame_end", fe_cnt, 1);
      check("good_crc_ok", fe_ok, 1'b1);
      check("good_frame_len", fe_len, 16'd12);

      add_frame(1'b1);
      run_stream(4);
      check("flip_frame_end", fe_cnt, 1);
      check("flip_crc_ok", fe_ok, 1'b0);
      check("flip_frame_len", fe_len, 16'd12);

      add_k(1'b0, 1'b1);
      add_k(1'b1, 1'b0);
      run_stream(4);
      check("short_frame_end", fe_cnt, 1);
      check("short_crc_ok", fe_ok, 1'b0);
      check("short_frame_len", fe_len, 16'd0);

      add_k(1'b0, 1'b1);
      add_byte(8'h55);
      add_byte(8'hAA);
      add_frame(1'b0);
      run_stream(4);
      check("restart_frame_end", fe_cnt, 1);
      check("restart_crc_ok", fe_ok, 1'b1);
      check("restart_frame_len", fe_len, 16'd12);

      add_k(1'b0, 1'b1);
      add_byte(payload[0]);
      add_byte(payload[1]);
      add_sym(1'b0, pack(6'b111111, 4'b0000));
      for (int i = 2; i < 8; i++) add_byte(payload[i]);
      add_k(1'b1, 1'b0);
      run_stream(4);
      check("abort_code_err_seen", ce_seen, 1'b1);
      check("abort_no_frame_end", fe_cnt, 0);

      do_reset();
      add_k(1'b0, 1'b1);
      add_byte(payload[0]);
      add_byte(payload[1]);
      add_byte(payload[2]);
      run_stream(0);
      @(negedge clk);
      pushin = 1'b0;
      reset  = 1'b1;
      #1;
      check("midframe_reset_outputs", all_outs(), 64'd0);
      repeat (2) @(negedge clk);
      check("midframe_reset_hold", all_outs(), 64'd0);
      reset = 1'b0;
      tb_rd = 1'b0;
      add_k(1'b1, 1'b0);
      run_stream(4);
      check("after_reset_no_frame_end", fe_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
